// File: rtl/irq_bus_controller.sv
// Memory-mapped interrupt controller: latches rising edges on int_req as pending,
// raises INT for the lowest masked-in source, and is acknowledged / retired by CPU bus writes.
`timescale 1ns/1ps
module irq_bus_controller #(
  parameter int unsigned N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_req,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      data_in,
  input  logic             mem_w,
  output logic [31:0]      data_out,
  output logic             INT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] R_PEND = 2'd0;
  localparam logic [1:0] R_MASK = 2'd1;
  localparam logic [1:0] R_VEC  = 2'd2;
  localparam logic [1:0] R_EOI  = 2'd3;

  logic [N_SRC-1:0] s1_q, s2_q, s3_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [3:0]       cur_id_q, cur_id_d;
  state_e           state_q;
  logic             int_q;

  logic             sel;
  logic             wr_en;
  logic [1:0]       reg_sel;
  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] w1c_bits;
  logic [N_SRC-1:0] ack_clr;
  logic [3:0]       prio_id;
  logic             ack_take;
  logic             eoi_take;
  logic             unused_bus_bits;

  assign sel      = (addr_in[31:4] == BASE_ADDR[31:4]);
  assign wr_en    = sel && mem_w;
  assign reg_sel  = addr_in[3:2];
  assign edge_det = s2_q & ~s3_q;
  assign active   = pending_q & mask_q;

  // ACK is only honoured in REQ with something still requesting; otherwise cur_id may be stale.
  assign ack_take = wr_en && (reg_sel == R_VEC) && (state_q == S_REQ) && (|active);
  assign eoi_take = wr_en && (reg_sel == R_EOI) && (state_q == S_SERVICE);
  assign w1c_bits = (wr_en && (reg_sel == R_PEND)) ? data_in[N_SRC-1:0] : '0;
  assign ack_clr  = ack_take ? (N_SRC'(1) << cur_id_q) : '0;

  assign unused_bus_bits = ^{addr_in[1:0], data_in};

  always_comb begin
    prio_id = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) prio_id = 4'(i);
    end
  end

  // New edges beat any clear arriving in the same cycle.
  always_comb begin
    pending_d = (pending_q & ~w1c_bits & ~ack_clr) | edge_det;
    mask_d    = (wr_en && (reg_sel == R_MASK)) ? data_in[N_SRC-1:0] : mask_q;
    cur_id_d  = cur_id_q;
    if (state_q == S_IDLE || (state_q == S_REQ && !ack_take)) begin
      cur_id_d = prio_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      cur_id_q  <= 4'd0;
    end else begin
      s1_q      <= int_req;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cur_id_q  <= cur_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      int_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|active) begin
            state_q <= S_REQ;
            int_q   <= 1'b1;
          end else begin
            int_q   <= 1'b0;
          end
        end
        S_REQ: begin
          if (active == '0) begin
            state_q <= S_IDLE;
            int_q   <= 1'b0;
          end else if (ack_take) begin
            state_q <= S_SERVICE;
            int_q   <= 1'b0;
          end else begin
            int_q   <= 1'b1;
          end
        end
        S_SERVICE: begin
          int_q <= 1'b0;
          if (eoi_take) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          int_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    data_out = 32'h0;
    if (sel) begin
      case (reg_sel)
        R_PEND:  data_out = {{(32-N_SRC){1'b0}}, pending_q};
        R_MASK:  data_out = {{(32-N_SRC){1'b0}}, mask_q};
        R_VEC:   data_out = {(state_q == S_SERVICE), (state_q == S_REQ), 26'b0, cur_id_q};
        default: data_out = 32'h0;
      endcase
    end
  end

  assign INT = int_q;

endmodule

// File: tb/tb_irq_bus_controller.sv
// Directed bench for irq_bus_controller with an expectation queue popped at each observation point.
`timescale 1ns/1ps
module tb_irq_bus_controller;

  localparam int unsigned N_SRC = 8;
  localparam logic [31:0] A_PEND = 32'hFFFF_FF00;
  localparam logic [31:0] A_MASK = 32'hFFFF_FF04;
  localparam logic [31:0] A_VEC  = 32'hFFFF_FF08;
  localparam logic [31:0] A_EOI  = 32'hFFFF_FF0C;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SRC-1:0] int_req;
  logic [31:0]      addr_in;
  logic [31:0]      data_in;
  logic             mem_w;
  logic [31:0]      data_out;
  logic             INT;

  int n_cmp = 0;
  int n_mis = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  irq_bus_controller #(.N_SRC(N_SRC), .BASE_ADDR(32'hFFFF_FF00)) dut (
    .clk      (clk),
    .reset    (reset),
    .int_req  (int_req),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .mem_w    (mem_w),
    .data_out (data_out),
    .INT      (INT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_mis++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic chk_rd(input logic [31:0] a);
    addr_in = a;
    #1;
    cmp(data_out);
    addr_in = 32'h0;
  endtask

  task automatic chk_int();
    cmp({31'b0, INT});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_in = a;
    data_in = d;
    mem_w   = 1'b1;
    tick();
    mem_w   = 1'b0;
    addr_in = 32'h0;
    data_in = 32'h0;
  endtask

  // Raise lines for exactly one clock: that clock edge is edge k.
  task automatic pulse(input logic [N_SRC-1:0] m);
    int_req = int_req | m;
    tick();
    int_req = int_req & ~m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    n_mis++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    int_req = '0;
    addr_in = 32'h0;
    data_in = 32'h0;
    mem_w   = 1'b0;
    tick();
    tick();
    push("rst_int", 32'h0);
    push("rst_pend", 32'h0);
    push("rst_vec", 32'h0);
    chk_int();
    chk_rd(A_PEND);
    chk_rd(A_VEC);
    reset = 1'b0;
    tick();

    // Test 1: single masked-in source, latency
    wr(A_MASK, 32'h04);
    push("t1_mask", 32'h04);
    chk_rd(A_MASK);
    pulse(8'h04);
    push("t1_pend_k1", 32'h0);
    push("t1_pend_k2", 32'h4);
    push("t1_int_k2", 32'h0);
    push("t1_int_k3", 32'h1);
    push("t1_vec_k3", 32'h4000_0002);
    tick();
    chk_rd(A_PEND);
    tick();
    chk_rd(A_PEND);
    chk_int();
    tick();
    chk_int();
    chk_rd(A_VEC);

    // Test 2: ACK then EOI
    wr(A_VEC, 32'h0);
    push("t2_int_ack", 32'h0);
    push("t2_pend_ack", 32'h0);
    push("t2_vec_ack", 32'h8000_0002);
    chk_int();
    chk_rd(A_PEND);
    chk_rd(A_VEC);
    wr(A_EOI, 32'h0);
    push("t2_vec_eoi", 32'h0000_0002);
    push("t2_int_eoi", 32'h0);
    chk_rd(A_VEC);
    chk_int();
    tick();
    push("t2_int_idle", 32'h0);
    push("t2_vec_idle", 32'h0);
    push("t2_eoi_read", 32'h0);
    chk_int();
    chk_rd(A_VEC);
    chk_rd(A_EOI);

    // Test 3: two simultaneous sources, priority and re-assert after EOI
    wr(A_MASK, 32'hFF);
    pulse(8'h22);
    push("t3_int_k3", 32'h1);
    push("t3_vec_k3", 32'h4000_0001);
    push("t3_pend_k3", 32'h22);
    tick();
    tick();
    tick();
    chk_int();
    chk_rd(A_VEC);
    chk_rd(A_PEND);
    wr(A_VEC, 32'h0);
    push("t3_pend_ack", 32'h20);
    push("t3_vec_ack", 32'h8000_0001);
    chk_rd(A_PEND);
    chk_rd(A_VEC);
    wr(A_EOI, 32'h0);
    push("t3_int_eoi", 32'h0);
    chk_int();
    tick();
    push("t3_int_reassert", 32'h1);
    push("t3_vec_reassert", 32'h4000_0005);
    chk_int();
    chk_rd(A_VEC);
    wr(A_VEC, 32'h0);
    wr(A_EOI, 32'h0);
    tick();
    push("t3_pend_clean", 32'h0);
    push("t3_int_clean", 32'h0);
    chk_rd(A_PEND);
    chk_int();

    // Test 4: masked pending, then unmask, then W1C withdraws the request
    wr(A_MASK, 32'h00);
    pulse(8'h08);
    tick();
    tick();
    tick();
    push("t4_pend_masked", 32'h8);
    push("t4_int_masked", 32'h0);
    chk_rd(A_PEND);
    chk_int();
    wr(A_MASK, 32'h08);
    push("t4_int_unmask_m", 32'h0);
    chk_int();
    tick();
    push("t4_int_unmask_m1", 32'h1);
    chk_int();
    wr(A_PEND, 32'h08);
    push("t4_int_w1c", 32'h1);
    push("t4_pend_w1c", 32'h0);
    chk_int();
    chk_rd(A_PEND);
    tick();
    push("t4_int_withdrawn", 32'h0);
    push("t4_vec_withdrawn", 32'h0);
    chk_int();
    chk_rd(A_VEC);

    // Test 5: edge during SERVICE accumulates; W1C vs simultaneous edge
    wr(A_MASK, 32'hFF);
    pulse(8'h10);
    tick();
    tick();
    tick();
    push("t5_vec_req4", 32'h4000_0004);
    chk_rd(A_VEC);
    wr(A_VEC, 32'h0);
    pulse(8'h01);
    tick();
    tick();
    tick();
    push("t5_pend_in_svc", 32'h1);
    push("t5_int_in_svc", 32'h0);
    push("t5_vec_in_svc", 32'h8000_0004);
    chk_rd(A_PEND);
    chk_int();
    chk_rd(A_VEC);
    wr(A_EOI, 32'h0);
    tick();
    push("t5_int_after_eoi", 32'h1);
    push("t5_vec_after_eoi", 32'h4000_0000);
    chk_int();
    chk_rd(A_VEC);
    wr(A_VEC, 32'h0);
    push("t5_pend_acked", 32'h0);
    chk_rd(A_PEND);
    int_req[0] = 1'b1;
    tick();
    tick();
    wr(A_PEND, 32'h01);
    push("t5_set_wins", 32'h1);
    chk_rd(A_PEND);
    tick();
    tick();
    wr(A_PEND, 32'h01);
    push("t5_held_no_reedge", 32'h0);
    chk_rd(A_PEND);
    int_req[0] = 1'b0;

    // Test 6: reset in SERVICE with PENDING=0x3
    pulse(8'h02);
    pulse(8'h01);
    tick();
    tick();
    push("t6_pend_pre", 32'h3);
    push("t6_vec_pre", 32'h8000_0000);
    chk_rd(A_PEND);
    chk_rd(A_VEC);
    reset = 1'b1;
    tick();
    push("t6_int_rst", 32'h0);
    push("t6_pend_rst", 32'h0);
    push("t6_mask_rst", 32'h0);
    push("t6_vec_rst", 32'h0);
    push("t6_unsel_rd", 32'h0);
    chk_int();
    chk_rd(A_PEND);
    chk_rd(A_MASK);
    chk_rd(A_VEC);
    reset = 1'b0;
    wr(A_MASK, 32'h5A);
    push("t6_unsel_rd_after", 32'h0);
    push("t6_mask_lowbits_ignored", 32'h5A);
    chk_rd(32'h0000_1234);
    chk_rd(32'h0000_1234);
    chk_rd(A_MASK | 32'h3);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_mis++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
